// File: rtl/tt_sweep_pkg.sv
// -----------------------------------------------------------------------------
// tt_sweep_pkg
// Shared types and helpers for the exhaustive truth-table sweeper.
//   tt_state_t : sweep FSM states (IDLE, APPLY, SAMPLE, DONE)
//   rows()     : number of input combinations for an N-input function
//   sat_add()  : saturating accumulate used for the mismatch counter
// -----------------------------------------------------------------------------
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    function automatic int unsigned rows(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Operands are carried at a fixed 16-bit width; callers zero-extend their
    // narrower counter and cap value, then truncate the result back.
    function automatic logic [15:0] sat_add(input logic [15:0] acc,
                                            input logic [15:0] inc,
                                            input logic [15:0] max_val);
        logic [16:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[15:0];
    endfunction

endpackage

// File: rtl/tt_row_compare.sv
// -----------------------------------------------------------------------------
// tt_row_compare
// Combinational per-row checker: picks the golden bit of every channel for the
// current row and flags channels whose DUT output disagrees.
// Ports:
//   dut_out  [N_CH-1:0]         sampled DUT outputs, channel 0 in bit 0
//   golden   [N_CH*2^N_IN-1:0]  golden table, bit ch*2^N_IN+row
//   row      [N_IN-1:0]         row currently applied
//   mismatch [N_CH-1:0]         per-channel mismatch for this row
//   popcnt   [PC_W-1:0]         number of mismatching channels
// -----------------------------------------------------------------------------
module tt_row_compare
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int N_CH = 4,
    localparam int ROWS = int'(rows(N_IN)),
    localparam int PC_W = $clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0]      dut_out,
    input  logic [N_CH*ROWS-1:0] golden,
    input  logic [N_IN-1:0]      row,
    output logic [N_CH-1:0]      mismatch,
    output logic [PC_W-1:0]      popcnt
);

    always_comb begin
        mismatch = '0;
        popcnt   = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            mismatch[ch] = dut_out[ch] ^ golden[ch*ROWS + int'(row)];
            popcnt       = popcnt + PC_W'(mismatch[ch]);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives every input combination of a combinational DUT in ascending order,
// holds each for SETTLE cycles, samples N_CH outputs and compares them against
// a golden truth table.
// Ports:
//   clk, reset      clock (rising edge), synchronous active-high reset
//   start           begin a sweep (honoured only in IDLE or DONE)
//   golden          golden table, bit ch*2^N_IN+row; hold stable during sweep
//   dut_out         DUT outputs, channel 0 in bit 0
//   stim            input vector driven to the DUT (MSB = input A)
//   busy            sweep in progress
//   done            one-cycle pulse on sweep completion
//   pass            no channel mismatched (valid in DONE)
//   ch_fail         sticky per-channel mismatch flags
//   err_count       saturating count of mismatching (row, channel) samples
//   first_fail_row  row of the first mismatch, qualified by first_fail_vld
// Build option:
//   TT_SWEEP_STOP_ON_FAIL_EN  when defined, the sweep ends at the first row
//                             that shows any mismatch.
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_CH   = 4,
    parameter int SETTLE = 1,
    localparam int ROWS  = int'(rows(N_IN)),
    localparam int ERR_W = N_IN + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N_CH*ROWS-1:0] golden,
    input  logic [N_CH-1:0]      dut_out,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_CH-1:0]      ch_fail,
    output logic [ERR_W-1:0]     err_count,
    output logic [N_IN-1:0]      first_fail_row,
    output logic                 first_fail_vld
);

    localparam int PC_W = $clog2(N_CH + 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [N_IN-1:0]  LAST_ROW = N_IN'(ROWS - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    tt_state_t        r_state;
    tt_state_t        w_next;
    logic [N_IN-1:0]  r_row;
    logic [3:0]       r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [N_CH-1:0]  r_ch_fail;
    logic [ERR_W-1:0] r_err;
    logic [N_IN-1:0]  r_ffr;
    logic             r_ffv;

    logic [N_CH-1:0]  w_mismatch;
    logic [PC_W-1:0]  w_popcnt;
    logic             w_last;

    tt_row_compare #(
        .N_IN (N_IN),
        .N_CH (N_CH)
    ) u_cmp (
        .dut_out  (dut_out),
        .golden   (golden),
        .row      (r_row),
        .mismatch (w_mismatch),
        .popcnt   (w_popcnt)
    );

    assign w_last = (r_row == LAST_ROW);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = APPLY;
            end
            APPLY: begin
                if (r_settle == SETTLE_LAST) w_next = SAMPLE;
            end
            SAMPLE: begin
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
                if (w_last || (|w_mismatch)) w_next = DONE;
                else                         w_next = APPLY;
`else
                if (w_last) w_next = DONE;
                else        w_next = APPLY;
`endif
            end
            DONE: begin
                if (start) w_next = APPLY;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row     <= '0;
            r_settle  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_ch_fail <= '0;
            r_err     <= '0;
            r_ffr     <= '0;
            r_ffv     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_row     <= '0;
                        r_settle  <= '0;
                        r_busy    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_ch_fail <= '0;
                        r_err     <= '0;
                        r_ffr     <= '0;
                        r_ffv     <= 1'b0;
                    end
                end
                APPLY: begin
                    r_settle <= r_settle + 4'd1;
                end
                SAMPLE: begin
                    r_settle  <= '0;
                    r_ch_fail <= r_ch_fail | w_mismatch;
                    r_err     <= ERR_W'(sat_add(16'(r_err), 16'(w_popcnt), 16'(ERR_MAX)));
                    if (!r_ffv && (|w_mismatch)) begin
                        r_ffv <= 1'b1;
                        r_ffr <= r_row;
                    end
                    // Leaving SAMPLE for DONE: the row stays put, so stim
                    // keeps showing the last (or failing) row.
                    if (w_next == DONE) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= ~|(r_ch_fail | w_mismatch);
                    end else begin
                        r_row <= r_row + N_IN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign stim           = r_row;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign ch_fail        = r_ch_fail;
    assign err_count      = r_err;
    assign first_fail_row = r_ffr;
    assign first_fail_vld = r_ffv;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters (4 inputs, 4 channels, SETTLE=1)
    logic        start_a = 1'b0;
    logic [63:0] gold_a;
    logic [3:0]  dout_a;
    logic [3:0]  stim_a;
    logic        busy_a, done_a, pass_a, ffv_a;
    logic [3:0]  chf_a, ffr_a;
    logic [7:0]  err_a;
    logic [3:0]  flip_a [16];

    // Instance B: 3 inputs, 2 channels, SETTLE=3
    logic        start_b = 1'b0;
    logic [15:0] gold_b;
    logic [1:0]  dout_b;
    logic [2:0]  stim_b;
    logic        busy_b, done_b, pass_b, ffv_b;
    logic [1:0]  chf_b;
    logic [2:0]  ffr_b;
    logic [6:0]  err_b;

    truth_table_sweeper #(.N_IN(4), .N_CH(4), .SETTLE(1)) dut_a (
        .clk(clk), .reset(rst), .start(start_a), .golden(gold_a), .dut_out(dout_a),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .ch_fail(chf_a),
        .err_count(err_a), .first_fail_row(ffr_a), .first_fail_vld(ffv_a)
    );

    truth_table_sweeper #(.N_IN(3), .N_CH(2), .SETTLE(3)) dut_b (
        .clk(clk), .reset(rst), .start(start_b), .golden(gold_b), .dut_out(dout_b),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .ch_fail(chf_b),
        .err_count(err_b), .first_fail_row(ffr_b), .first_fail_vld(ffv_b)
    );

    // Gate functions under test, with optional per-row fault injection on A
    always_comb begin
        dout_a = '0;
        for (int ch = 0; ch < 4; ch++)
            dout_a[ch] = gold_a[ch*16 + int'(stim_a)] ^ flip_a[stim_a][ch];
    end

    always_comb begin
        dout_b = '0;
        for (int ch = 0; ch < 2; ch++)
            dout_b[ch] = gold_b[ch*8 + int'(stim_b)];
    end

    typedef struct {
        logic       pass;
        logic [3:0] chf;
        logic [7:0] err;
        logic [3:0] ffr;
        logic       ffv;
        int         done_cyc;
        logic [3:0] last_stim;
    } exp_t;

    exp_t sb_q[$];

    task automatic build_golden();
        logic [3:0] r;
        logic [2:0] rb;
        for (int i = 0; i < 16; i++) begin
            r = 4'(i);
            gold_a[0*16 + i] = &r;
            gold_a[1*16 + i] = |r;
            gold_a[2*16 + i] = ^r;
            gold_a[3*16 + i] = ~(r[3] & r[2]);
        end
        for (int i = 0; i < 8; i++) begin
            rb = 3'(i);
            gold_b[0*8 + i] = ^rb;
            gold_b[1*8 + i] = (rb[0] & rb[1]) | (rb[1] & rb[2]) | (rb[0] & rb[2]);
        end
    endtask

    task automatic clear_flips();
        for (int i = 0; i < 16; i++) flip_a[i] = 4'h0;
    endtask

    // Reference model of one sweep on instance A given the injected faults
    task automatic model_a(output exp_t e);
        logic [3:0] mm;
        int rows_run;
        e.chf = '0; e.err = '0; e.ffr = '0; e.ffv = 1'b0;
        rows_run = 0;
        for (int r = 0; r < 16; r++) begin
            mm = flip_a[r];
            e.chf = e.chf | mm;
            e.err = e.err + 8'($countones(mm));
            if (!e.ffv && mm != 4'h0) begin
                e.ffv = 1'b1;
                e.ffr = 4'(r);
            end
            rows_run = r + 1;
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
            if (mm != 4'h0) break;
`endif
        end
        e.pass      = (e.chf == 4'h0);
        e.done_cyc  = rows_run * 2 + 1;
        e.last_stim = 4'(rows_run - 1);
    endtask

    task automatic run_a(input string tag);
        exp_t e, g;
        int cyc, bad_stim, bad_busy;
        bit got;
        logic [3:0] bs_act, bs_exp;
        model_a(e);
        sb_q.push_back(e);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        cyc = 1; got = 0; bad_stim = 0; bad_busy = 0; bs_act = '0; bs_exp = '0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            if (done_a) begin
                got = 1;
            end else begin
                if (stim_a !== 4'((cyc - 1) / 2)) begin
                    if (bad_stim == 0) begin bs_act = stim_a; bs_exp = 4'((cyc - 1) / 2); end
                    bad_stim++;
                end
                if (busy_a !== 1'b1) bad_busy++;
                @(posedge clk);
                cyc++;
            end
        end
        g = sb_q.pop_front();
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s done_timeout: no done within %0d cycles, required at cycle %0d", tag, cyc, g.done_cyc);
            return;
        end
        checks++; if (bad_stim != 0) begin failures++; $display("FAIL %s stim_seq: %0d bad cycles, first got %0d required %0d", tag, bad_stim, bs_act, bs_exp); end
        checks++; if (bad_busy != 0) begin failures++; $display("FAIL %s busy_seq: busy low in %0d sweep cycles, required 0", tag, bad_busy); end
        checks++; if (cyc != g.done_cyc) begin failures++; $display("FAIL %s done_cycle: got %0d required %0d", tag, cyc, g.done_cyc); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL %s busy_at_done: got %b required 0", tag, busy_a); end
        checks++; if (pass_a !== g.pass) begin failures++; $display("FAIL %s pass: got %b required %b", tag, pass_a, g.pass); end
        checks++; if (chf_a !== g.chf) begin failures++; $display("FAIL %s ch_fail: got %b required %b", tag, chf_a, g.chf); end
        checks++; if (err_a !== g.err) begin failures++; $display("FAIL %s err_count: got %0d required %0d", tag, err_a, g.err); end
        checks++; if (ffv_a !== g.ffv) begin failures++; $display("FAIL %s first_fail_vld: got %b required %b", tag, ffv_a, g.ffv); end
        if (g.ffv) begin
            checks++; if (ffr_a !== g.ffr) begin failures++; $display("FAIL %s first_fail_row: got %0d required %0d", tag, ffr_a, g.ffr); end
        end
        checks++; if (stim_a !== g.last_stim) begin failures++; $display("FAIL %s final_stim: got %0d required %0d", tag, stim_a, g.last_stim); end
        @(negedge clk);
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL %s done_pulse: done still %b one cycle later, required 0", tag, done_a); end
        checks++; if (err_a !== g.err || pass_a !== g.pass) begin failures++; $display("FAIL %s result_hold: err %0d pass %b, required %0d %b", tag, err_a, pass_a, g.err, g.pass); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({stim_a, busy_a, done_a, pass_a, chf_a, err_a, ffr_a, ffv_a} !== 24'h0) begin
            failures++; $display("FAIL reset_a: outputs %h required 0", {stim_a, busy_a, done_a, pass_a, chf_a, err_a, ffr_a, ffv_a});
        end
        checks++; if ({stim_b, busy_b, done_b, pass_b, chf_b, err_b, ffr_b, ffv_b} !== 19'h0) begin
            failures++; $display("FAIL reset_b: outputs %h required 0", {stim_b, busy_b, done_b, pass_b, chf_b, err_b, ffr_b, ffv_b});
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_clean_sweep();
        clear_flips();
        run_a("clean");
    endtask

    task automatic test_single_fault();
        clear_flips();
        flip_a[5] = 4'b0100;
        run_a("ch2_row5");
    endtask

    task automatic test_all_wrong();
        for (int i = 0; i < 16; i++) flip_a[i] = 4'hF;
        run_a("all_wrong");
    endtask

    task automatic test_back_to_back();
        // Restart straight from DONE of the previous sweep; results must clear
        clear_flips();
        flip_a[0]  = 4'b0001;
        flip_a[15] = 4'b1000;
        run_a("restart_from_done");
        clear_flips();
        run_a("restart_clean");
    endtask

    task automatic test_row9_fault();
        clear_flips();
        flip_a[9] = 4'b0010;
        run_a("row9");
    endtask

    task automatic test_settle3_busy_start();
        int cyc, bad_stim;
        bit got;
        logic [2:0] bs_act, bs_exp;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        cyc = 1; got = 0; bad_stim = 0; bs_act = '0; bs_exp = '0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            if (done_b) begin
                got = 1;
            end else begin
                if (stim_b !== 3'((cyc - 1) / 4)) begin
                    if (bad_stim == 0) begin bs_act = stim_b; bs_exp = 3'((cyc - 1) / 4); end
                    bad_stim++;
                end
                @(posedge clk); #1;
                cyc++;
                start_b = (cyc == 10);
            end
        end
        start_b = 1'b0;
        checks++; if (!got) begin failures++; $display("FAIL settle3 done_timeout: no done within %0d cycles", cyc); end
        checks++; if (bad_stim != 0) begin failures++; $display("FAIL settle3 stim_seq: %0d bad cycles, first got %0d required %0d", bad_stim, bs_act, bs_exp); end
        checks++; if (cyc != 33) begin failures++; $display("FAIL settle3 done_cycle: got %0d required 33", cyc); end
        checks++; if ({pass_b, chf_b, err_b, ffv_b} !== {1'b1, 2'b00, 7'd0, 1'b0}) begin
            failures++; $display("FAIL settle3 results: pass %b ch_fail %b err %0d vld %b, required 1 00 0 0", pass_b, chf_b, err_b, ffv_b);
        end
        checks++; if (stim_b !== 3'd7 || busy_b !== 1'b0) begin failures++; $display("FAIL settle3 final: stim %0d busy %b, required 7 0", stim_b, busy_b); end
    endtask

    task automatic test_reset_mid_sweep();
        int n, dones;
        bit seen;
        clear_flips();
        flip_a[2] = 4'b0011;  // accumulate some results before the abort
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        seen = 0; n = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            if (stim_a == 4'd7) seen = 1;
            n++;
        end
        checks++; if (!seen) begin failures++; $display("FAIL abort row7_timeout: stim %0d, required to reach 7", stim_a); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({stim_a, busy_a, done_a, pass_a, chf_a, err_a, ffr_a, ffv_a} !== 24'h0) begin
            failures++; $display("FAIL abort_outputs: got %h required 0", {stim_a, busy_a, done_a, pass_a, chf_a, err_a, ffr_a, ffv_a});
        end
        @(posedge clk); #1 rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL abort_no_done: %0d done pulses, required 0", dones); end
        clear_flips();
        run_a("after_abort");
    endtask

    initial begin
        clear_flips();
        build_golden();
        test_reset();
        test_clean_sweep();
        test_single_fault();
        test_all_wrong();
        test_back_to_back();
        test_row9_fault();
        test_settle3_busy_start();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
